jtldtest_bist: RTL

JTLDTEST_BIST -- requirements
Module: jtldtest_bist

---
 rtl/jtldtest_pkg.sv | 22 ++
 rtl/jtldtest_lfsr.sv | 28 ++
 rtl/jtldtest_bist.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/jtldtest_pkg.sv
// Shared definitions for the SDRAM bank BIST: controller states, LFSR taps/seed
// and the Galois LFSR step function.
package jtldtest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_W,
        READ,
        WAIT_R,
        DONE
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Galois form, shifting right: feedback taps applied when bit 0 falls out
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/jtldtest_lfsr.sv
// 16-bit pattern generator for the BIST; load has priority over advance.
module jtldtest_lfsr
    import jtldtest_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] value_o
);

    logic [15:0] value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= SEED;
        end else if (load_i) begin
            value_q <= SEED;
        end else if (adv_i) begin
            value_q <= lfsr_next(value_q);
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/jtldtest_bist.sv
// SDRAM bank BIST: writes an LFSR pattern to every bank, reads it back and flags
// mismatching banks. Define JTLDTEST_ERRLOG_EN for error counters and first-fail capture.
module jtldtest_bist
    import jtldtest_pkg::*;
#(
    parameter int            BANKS = 4,
    parameter int            AW    = 22,
    parameter logic [AW-1:0] LAST  = 22'h3F_FFFF,
    parameter logic [15:0]   SEED  = LFSR_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic [BANKS-1:0]   bad,
    output logic [8*BANKS-1:0] err_cnt,
    output logic [AW-1:0]      fail_addr,
    output logic [1:0]         fail_ba,
    output logic [AW-1:0]      ba_addr,
    output logic [BANKS-1:0]   ba_rd,
    output logic [BANKS-1:0]   ba_wr,
    output logic [15:0]        ba_din,
    output logic [1:0]         ba_din_m,
    input  logic [BANKS-1:0]   ba_ack,
    input  logic [BANKS-1:0]   ba_rdy,
    input  logic [15:0]        data_read,
    output logic               refresh_en
);

    state_e           state_q, state_d;
    logic [1:0]       bank_q, bank_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [BANKS-1:0] bad_q, bad_d;
    logic [BANKS-1:0] sel;
    logic             ack_cur, rdy_cur;
    logic             lfsr_load, lfsr_adv;
    logic             clear, mismatch, step, rd_phase;
    logic [15:0]      lfsr;

    jtldtest_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .adv_i   (lfsr_adv),
        .value_o (lfsr)
    );

    // One-hot of the bank under test; handshakes from other banks are masked off
    assign sel     = BANKS'(1) << bank_q;
    assign ack_cur = |(ba_ack & sel);
    assign rdy_cur = |(ba_rdy & sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        bad_d     = bad_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        clear     = 1'b0;
        mismatch  = 1'b0;
        step      = 1'b0;
        rd_phase  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = WRITE;
                    bank_d    = '0;
                    addr_d    = '0;
                    lfsr_load = 1'b1;
                    clear     = 1'b1;
                end
            end
            WRITE: begin
                if (stop)         state_d = IDLE;
                else if (ack_cur) state_d = WAIT_W;
            end
            WAIT_W: begin
                if (stop)         state_d = IDLE;
                else if (rdy_cur) step = 1'b1;
            end
            READ: begin
                if (stop)         state_d = IDLE;
                else if (ack_cur) state_d = WAIT_R;
            end
            WAIT_R: begin
                rd_phase = 1'b1;
                if (stop) begin
                    state_d = IDLE;
                end else if (rdy_cur) begin
                    step     = 1'b1;
                    mismatch = (data_read != lfsr);
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared word advance for both phases; a seed reload overrides the step
        if (step) begin
            lfsr_adv = 1'b1;
            if (addr_q != LAST) begin
                addr_d  = addr_q + 1'b1;
                state_d = rd_phase ? READ : WRITE;
            end else begin
                addr_d = '0;
                if (bank_q == 2'(BANKS - 1)) begin
                    bank_d    = '0;
                    lfsr_load = 1'b1;
                    state_d   = rd_phase ? DONE : READ;
                end else begin
                    bank_d  = bank_q + 2'd1;
                    state_d = rd_phase ? READ : WRITE;
                end
            end
        end

        if (clear)         bad_d = '0;
        else if (mismatch) bad_d = bad_q | sel;
    end

    assign busy       = (state_q == WRITE) || (state_q == WAIT_W) ||
                        (state_q == READ)  || (state_q == WAIT_R);
    assign done       = (state_q == DONE);
    assign refresh_en = ~busy;
    assign bad        = bad_q;
    assign ba_addr    = addr_q;
    assign ba_wr      = (state_q == WRITE) ? sel : '0;
    assign ba_rd      = (state_q == READ)  ? sel : '0;
    assign ba_din     = (state_q == WRITE) ? lfsr : '0;
    assign ba_din_m   = (state_q == WRITE) ? 2'b00 : 2'b11;

`ifdef JTLDTEST_ERRLOG_EN
    logic [8*BANKS-1:0] err_cnt_q, err_cnt_d;
    logic [AW-1:0]      fail_addr_q;
    logic [1:0]         fail_ba_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear) begin
            err_cnt_d = '0;
        end else if (mismatch) begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                if (sel[b] && err_cnt_q[8*b +: 8] != 8'hFF)
                    err_cnt_d[8*b +: 8] = err_cnt_q[8*b +: 8] + 8'd1;
            end
        end
    end

    // bad_q is all-zero until the first mismatch of a run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
            fail_ba_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (clear) begin
                fail_addr_q <= '0;
                fail_ba_q   <= '0;
            end else if (mismatch && bad_q == '0) begin
                fail_addr_q <= addr_q;
                fail_ba_q   <= bank_q;
            end
        end
    end

    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_ba   = fail_ba_q;
`else
    assign err_cnt   = '0;
    assign fail_addr = '0;
    assign fail_ba   = '0;
`endif

endmodule
